// File: rtl/init_data_ctrl.sv
// init_data_ctrl: burst sequencer that streams LFSR test patterns or host pass-through data.
// Define INIT_DATA_CTRL_CHECKSUM_EN to enable the running XOR checksum of delivered beats.
module init_data_ctrl #(
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               cfg_mode,
    input  logic [15:0]        cfg_seed,
    input  logic [BURST_W-1:0] cfg_len,
    input  logic [15:0]        host_data,
    input  logic               host_valid,
    output logic               host_ready,
    output logic [15:0]        out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy,
    output logic               done,
    output logic [15:0]        checksum
);
    typedef enum logic [1:0] {IDLE, SEED, STREAM, DONE} state_t;
    state_t state;
    logic mode;
    logic [15:0] seed, lfsr;
    logic [BURST_W-1:0] len, cnt;
    logic stream, hs;
    assign stream     = state == STREAM;
    assign out_valid  = stream & (mode ? host_valid : 1'b1);
    assign host_ready = stream & mode & out_ready;
    assign out_data   = (stream & mode) ? host_data : lfsr;
    assign out_last   = stream & (cnt == BURST_W'(1));
    assign hs         = out_valid & out_ready;
    assign busy       = state != IDLE;
    assign done       = state == DONE;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            mode  <= 1'b0;
            seed  <= '0;
            len   <= '0;
            lfsr  <= 16'h0010;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mode  <= cfg_mode;
                    seed  <= cfg_seed;
                    len   <= cfg_len;
                    state <= SEED;
                end
                SEED: begin
                    // an all-zero seed would lock the LFSR, so substitute a legal one
                    lfsr  <= (seed == 16'h0000) ? 16'h0010 : seed;
                    cnt   <= len;
                    state <= (len == '0) ? DONE : STREAM;
                end
                STREAM: if (hs) begin
                    cnt <= cnt - 1'b1;
                    if (!mode) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                    if (cnt == BURST_W'(1)) state <= DONE;
                end
                DONE: state <= IDLE;
            endcase
        end
    end
`ifdef INIT_DATA_CTRL_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || state == SEED) checksum <= '0;
        else if (hs) checksum <= checksum ^ out_data;
    end
`else
    assign checksum = 16'h0000;
`endif
endmodule
